vlane_commit_agg: RTL and testbench



---
 rtl/vlane_commit_agg.sv | 199 +++++++++++++++++++
 tb/tb_vlane_commit_agg.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vlane_commit_agg.sv
// ---------------------------------------------------------------------------
// vlane_commit_agg
//
// Collects per-lane commit pulses from the vector lane array and retires each
// issued vector instruction, in allocation order, once every participating
// lane has committed it. A single instruction at a time is handed to the
// scalar/commit side over a valid/ack handshake.
//
// Ports:
//   clock            system clock
//   reset            asynchronous reset, active low
//   I_Issue_Req      allocate a table entry for a newly issued instruction
//   I_Issue_No       issue number of the allocating instruction
//   I_Lane_Mask      lanes participating in the instruction
//   O_Issue_Ack      allocation accepted this cycle (combinational)
//   O_Full           table full (registered state)
//   O_Empty          no valid entries (registered state)
//   O_Count          number of valid entries
//   I_Lane_Commit    per-lane commit pulse
//   I_Lane_Commit_No per-lane issue number, lane k at [k*WIDTH_ISSUE +: WIDTH_ISSUE]
//   O_Commit         head instruction fully committed and presented
//   O_Commit_No      issue number of the presented instruction
//   I_Commit_Ack     consumer accepts the presented commit
//   O_Err            sticky protocol error (duplicate issue, stray lane commit)
// ---------------------------------------------------------------------------
module vlane_commit_agg #(
    parameter int NUM_LANES   = 16,
    parameter int WIDTH_ISSUE = 6,
    parameter int DEPTH       = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             I_Issue_Req,
    input  logic [WIDTH_ISSUE-1:0]           I_Issue_No,
    input  logic [NUM_LANES-1:0]             I_Lane_Mask,
    output logic                             O_Issue_Ack,
    output logic                             O_Full,
    output logic                             O_Empty,
    output logic [$clog2(DEPTH+1)-1:0]       O_Count,
    input  logic [NUM_LANES-1:0]             I_Lane_Commit,
    input  logic [NUM_LANES*WIDTH_ISSUE-1:0] I_Lane_Commit_No,
    output logic                             O_Commit,
    output logic [WIDTH_ISSUE-1:0]           O_Commit_No,
    input  logic                             I_Commit_Ack,
    output logic                             O_Err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Table state: valid bits are control (reset), payload is data (no reset)
    logic [DEPTH-1:0]       valid_q;
    logic [WIDTH_ISSUE-1:0] issue_q [DEPTH];
    logic [NUM_LANES-1:0]   pend_q  [DEPTH];

    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;
    state_t                 state_q;
    state_t                 state_d;
    logic [WIDTH_ISSUE-1:0] commit_no_q;
    logic                   err_q;

    logic                   full;
    logic                   dup;
    logic                   issue_ack;
    logic                   head_done;
    logic                   load_commit;
    logic                   retire;
    logic [NUM_LANES-1:0]   lane_hit;
    logic [NUM_LANES-1:0]   lane_err;
    logic [NUM_LANES-1:0]   clr [DEPTH];

    assign full = (count_q == CNT_W'(DEPTH));

    // Duplicate detection against every currently valid entry
    always_comb begin
        dup = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (valid_q[e] && (issue_q[e] == I_Issue_No)) begin
                dup = 1'b1;
            end
        end
    end

    // A same-cycle retire does not free a slot: full is from registered count
    assign issue_ack = I_Issue_Req & ~full & ~dup;

    // Lane commit matching. Issue numbers are unique among valid entries, so at
    // most one entry can hit per lane; a lane that finds no still-pending entry
    // is a protocol error.
    always_comb begin
        lane_hit = '0;
        lane_err = '0;
        for (int e = 0; e < DEPTH; e++) begin
            clr[e] = '0;
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (I_Lane_Commit[k] && valid_q[e] && pend_q[e][k] &&
                    (issue_q[e] == I_Lane_Commit_No[k*WIDTH_ISSUE +: WIDTH_ISSUE])) begin
                    clr[e][k]   = 1'b1;
                    lane_hit[k] = 1'b1;
                end
            end
            lane_err[k] = I_Lane_Commit[k] & ~lane_hit[k];
        end
    end

    assign head_done = valid_q[head_q] && (pend_q[head_q] == '0);

    // Output FSM next-state logic
    always_comb begin
        state_d     = state_q;
        load_commit = 1'b0;
        retire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_done) begin
                    load_commit = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (I_Commit_Ack) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state: pointers, valid bits, count, FSM, presented number, error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            commit_no_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_commit) begin
                commit_no_q <= issue_q[head_q];
            end
            // Head and tail never coincide here: an ack implies not full, so
            // the tail slot is invalid while the retiring head slot is valid.
            for (int e = 0; e < DEPTH; e++) begin
                if (retire && (head_q == PTR_W'(e))) begin
                    valid_q[e] <= 1'b0;
                end
                if (issue_ack && (tail_q == PTR_W'(e))) begin
                    valid_q[e] <= 1'b1;
                end
            end
            if (issue_ack) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (retire) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({issue_ack, retire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            err_q <= err_q | (I_Issue_Req & dup) | (|lane_err);
        end
    end

    // Table payload: allocation writes the tail slot, lane commits clear bits
    always_ff @(posedge clock) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (issue_ack && (tail_q == PTR_W'(e))) begin
                issue_q[e] <= I_Issue_No;
                pend_q[e]  <= I_Lane_Mask;
            end else begin
                pend_q[e]  <= pend_q[e] & ~clr[e];
            end
        end
    end

    assign O_Issue_Ack = issue_ack;
    assign O_Full      = full;
    assign O_Empty     = (count_q == '0);
    assign O_Count     = count_q;
    assign O_Commit    = (state_q == ST_PRESENT);
    assign O_Commit_No = commit_no_q;
    assign O_Err       = err_q;

endmodule

// File: tb/tb_vlane_commit_agg.sv
// ---------------------------------------------------------------------------
// Testbench for vlane_commit_agg: directed stimulus, a queue-based reference
// model of the instruction table checked every cycle, and literal expectations
// at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_vlane_commit_agg;

    localparam int NL = 16;
    localparam int WI = 6;
    localparam int DP = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            I_Issue_Req;
    logic [WI-1:0]   I_Issue_No;
    logic [NL-1:0]   I_Lane_Mask;
    logic            O_Issue_Ack;
    logic            O_Full;
    logic            O_Empty;
    logic [3:0]      O_Count;
    logic [NL-1:0]   I_Lane_Commit;
    logic [NL*WI-1:0] I_Lane_Commit_No;
    logic            O_Commit;
    logic [WI-1:0]   O_Commit_No;
    logic            I_Commit_Ack;
    logic            O_Err;

    int n_chk  = 0;
    int n_fail = 0;

    vlane_commit_agg #(.NUM_LANES(NL), .WIDTH_ISSUE(WI), .DEPTH(DP)) dut (
        .clock            (clock),
        .reset            (reset),
        .I_Issue_Req      (I_Issue_Req),
        .I_Issue_No       (I_Issue_No),
        .I_Lane_Mask      (I_Lane_Mask),
        .O_Issue_Ack      (O_Issue_Ack),
        .O_Full           (O_Full),
        .O_Empty          (O_Empty),
        .O_Count          (O_Count),
        .I_Lane_Commit    (I_Lane_Commit),
        .I_Lane_Commit_No (I_Lane_Commit_No),
        .O_Commit         (O_Commit),
        .O_Commit_No      (O_Commit_No),
        .I_Commit_Ack     (I_Commit_Ack),
        .O_Err            (O_Err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [WI-1:0] no;
        logic [NL-1:0] pend;
    } ent_t;

    ent_t          mq[$];
    bit            m_present;
    logic [WI-1:0] m_no;
    bit            m_err;

    function automatic bit m_dup(input logic [WI-1:0] n);
        foreach (mq[i]) if (mq[i].no == n) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ack();
        return I_Issue_Req && (mq.size() < DP) && !m_dup(I_Issue_No);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_present = 1'b0;
            m_no      = '0;
            m_err     = 1'b0;
        end else begin
            bit            a;
            bit            r;
            bit            pres;
            bit            found;
            logic [WI-1:0] lno;
            ent_t          tmp;
            a    = m_ack();
            r    = m_present && I_Commit_Ack;
            pres = !m_present && (mq.size() > 0) && (mq[0].pend == '0);
            if (I_Issue_Req && m_dup(I_Issue_No)) m_err = 1'b1;
            for (int k = 0; k < NL; k++) begin
                if (I_Lane_Commit[k]) begin
                    found = 1'b0;
                    lno   = I_Lane_Commit_No[k*WI +: WI];
                    foreach (mq[i]) begin
                        if (mq[i].no == lno && mq[i].pend[k]) begin
                            tmp         = mq[i];
                            tmp.pend[k] = 1'b0;
                            mq[i]       = tmp;
                            found       = 1'b1;
                        end
                    end
                    if (!found) m_err = 1'b1;
                end
            end
            if (pres) begin
                m_present = 1'b1;
                m_no      = mq[0].no;
            end
            if (r) begin
                void'(mq.pop_front());
                m_present = 1'b0;
            end
            if (a) begin
                tmp.no   = I_Issue_No;
                tmp.pend = I_Lane_Mask;
                mq.push_back(tmp);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (reset) begin
            chk("m_commit", O_Commit, m_present);
            if (m_present) chk("m_commit_no", O_Commit_No, m_no);
            chk("m_err",   O_Err,   m_err);
            chk("m_count", O_Count, mq.size());
            chk("m_full",  O_Full,  mq.size() == DP);
            chk("m_empty", O_Empty, mq.size() == 0);
            chk("m_ack",   O_Issue_Ack, m_ack());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic lanes(input logic [NL-1:0] m, input logic [WI-1:0] no);
        I_Lane_Commit = m;
        for (int k = 0; k < NL; k++) I_Lane_Commit_No[k*WI +: WI] = no;
    endtask

    task automatic retire_expect(input logic [WI-1:0] no);
        int w = 0;
        while (!O_Commit && w < 20) begin
            step();
            w++;
        end
        chk("commit_wait", O_Commit, 1);
        chk("commit_no_order", O_Commit_No, no);
        I_Commit_Ack = 1'b1;
        step();
        I_Commit_Ack = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        I_Issue_Req      = 1'b0;
        I_Issue_No       = '0;
        I_Lane_Mask      = '0;
        I_Lane_Commit    = '0;
        I_Lane_Commit_No = '0;
        I_Commit_Ack     = 1'b0;
        #2;
        chk("rst_commit", O_Commit, 0);
        chk("rst_no",     O_Commit_No, 0);
        chk("rst_err",    O_Err, 0);
        chk("rst_full",   O_Full, 0);
        chk("rst_empty",  O_Empty, 1);
        chk("rst_count",  O_Count, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();

        // Scenario 1: issue 5, two lanes commit two cycles apart
        I_Issue_Req = 1'b1; I_Issue_No = 6'd5; I_Lane_Mask = 16'h0003;
        #1 chk("s1_alloc_ack", O_Issue_Ack, 1);
        step();
        I_Issue_Req = 1'b0;
        lanes(16'h0001, 6'd5); step();     // cycle t
        lanes(16'h0000, 6'd0); step();     // t+1
        lanes(16'h0002, 6'd5); step();     // t+2
        lanes(16'h0000, 6'd0);             // t+3
        chk("s1_commit_t3", O_Commit, 0);
        step();                            // t+4
        chk("s1_commit_t4", O_Commit, 1);
        chk("s1_no_t4", O_Commit_No, 5);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s1_hold_commit", O_Commit, 1);
            chk("s1_hold_no", O_Commit_No, 5);
        end
        I_Commit_Ack = 1'b1; step(); I_Commit_Ack = 1'b0;
        chk("s1_commit_low", O_Commit, 0);
        chk("s1_empty", O_Empty, 1);

        // Scenario 2: lanes commit out of order, retire stays in order
        for (int i = 1; i <= 3; i++) begin
            I_Issue_Req = 1'b1; I_Issue_No = WI'(i); I_Lane_Mask = 16'hFFFF;
            step();
        end
        I_Issue_Req = 1'b0;
        lanes(16'hFFFF, 6'd3); step();
        lanes(16'hFFFF, 6'd2); step();
        lanes(16'hFFFF, 6'd1); step();
        lanes(16'h0000, 6'd0);
        retire_expect(6'd1);
        retire_expect(6'd2);
        retire_expect(6'd3);
        chk("s2_no_err", O_Err, 0);
        chk("s2_empty", O_Empty, 1);

        // Scenario 3: fill, refuse when full, retire+request same cycle
        for (int i = 0; i < DP; i++) begin
            I_Issue_Req = 1'b1; I_Issue_No = WI'(10 + i); I_Lane_Mask = 16'h0001;
            step();
        end
        chk("s3_full", O_Full, 1);
        chk("s3_count", O_Count, 8);
        I_Issue_No = 6'd20;
        #1 chk("s3_ack_full", O_Issue_Ack, 0);
        lanes(16'h0001, 6'd10); step();
        lanes(16'h0000, 6'd0);
        for (int w = 0; w < 10 && !O_Commit; w++) step();
        chk("s3_head_present", O_Commit, 1);
        I_Commit_Ack = 1'b1;
        #1 chk("s3_ack_during_retire", O_Issue_Ack, 0);
        step();
        I_Commit_Ack = 1'b0;
        #1 chk("s3_ack_after_retire", O_Issue_Ack, 1);
        step();
        I_Issue_Req = 1'b0;
        chk("s3_full_again", O_Full, 1);
        chk("s3_count_again", O_Count, 8);
        for (int i = 11; i <= 17; i++) begin
            lanes(16'h0001, WI'(i)); step();
        end
        lanes(16'h0001, 6'd20); step();
        lanes(16'h0000, 6'd0);
        for (int i = 11; i <= 17; i++) retire_expect(WI'(i));
        retire_expect(6'd20);
        chk("s3_drained", O_Empty, 1);

        // Scenario 4: stray lane commit and duplicate allocation
        lanes(16'h0010, 6'd9); step();
        lanes(16'h0000, 6'd0);
        chk("s4_err", O_Err, 1);
        chk("s4_count", O_Count, 0);
        I_Issue_Req = 1'b1; I_Issue_No = 6'd7; I_Lane_Mask = 16'h0000;
        step();
        #1 chk("s4_dup_ack", O_Issue_Ack, 0);
        step();
        I_Issue_Req = 1'b0;
        chk("s4_err_sticky", O_Err, 1);
        chk("s4_count_one", O_Count, 1);
        retire_expect(6'd7);

        // Scenario 5: zero mask completes without lane commits
        I_Issue_Req = 1'b1; I_Issue_No = 6'd2; I_Lane_Mask = 16'h0000;
        step();
        I_Issue_Req = 1'b0;
        chk("s5_commit_c1", O_Commit, 0);
        step();
        chk("s5_commit_c2", O_Commit, 1);
        chk("s5_no", O_Commit_No, 2);
        I_Commit_Ack = 1'b1; step(); I_Commit_Ack = 1'b0;

        // Scenario 6: asynchronous reset while presenting with 4 entries
        for (int i = 0; i < 4; i++) begin
            I_Issue_Req = 1'b1; I_Issue_No = WI'(30 + i); I_Lane_Mask = 16'h0000;
            step();
        end
        I_Issue_Req = 1'b0;
        chk("s6_commit_pre", O_Commit, 1);
        chk("s6_count_pre", O_Count, 4);
        #2 reset = 1'b0;
        #1;
        chk("s6_rst_commit", O_Commit, 0);
        chk("s6_rst_no", O_Commit_No, 0);
        chk("s6_rst_err", O_Err, 0);
        chk("s6_rst_full", O_Full, 0);
        chk("s6_rst_empty", O_Empty, 1);
        chk("s6_rst_count", O_Count, 0);
        step();
        reset = 1'b1;
        step();
        chk("s6_empty_after", O_Empty, 1);
        chk("s6_commit_after", O_Commit, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
